// File: rtl/uart8_tx_arbiter.sv
`default_nettype none
// =============================================================================
// Module      : uart8_tx_arbiter
// Description : Round-robin arbiter sharing one 8-bit UART transmitter among
//               NUM_REQ byte producers. Optional frame watchdog is enabled by
//               defining UART_TX_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// =============================================================================
module uart8_tx_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int WD_LIMIT = 15
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] data,
   output logic [NUM_REQ-1:0]   grant,
   output logic [NUM_REQ-1:0]   ack,
   output logic                 err,
   output logic                 tx_start,
   output logic [7:0]           tx_data,
   input  logic                 tx_busy,
   input  logic                 tx_done
);

   localparam int c_ptr_w = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
   localparam logic [c_ptr_w:0] c_num = (c_ptr_w + 1)'(NUM_REQ);

   typedef enum logic [2:0] {
      ARB_IDLE = 3'd0,
      LAUNCH   = 3'd1,
      SEND     = 3'd2,
      RELEASE  = 3'd3,
      GAP      = 3'd4
   } state_t;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 || WD_LIMIT < 4 || WD_LIMIT > 255) begin : g_param_check
         $error("uart8_tx_arbiter: NUM_REQ or WD_LIMIT outside legal range");
      end
   endgenerate

   state_t               r_state;
   logic [c_ptr_w-1:0]   r_ptr;
   logic [c_ptr_w-1:0]   r_winner;

   logic [c_ptr_w-1:0]   w_win_idx;
   logic                 w_win_found;
   logic [7:0]           w_win_byte;
   logic [NUM_REQ-1:0]   w_win_onehot;
   logic [c_ptr_w-1:0]   w_ptr_next;

   // (base + offs) mod NUM_REQ; both operands are below NUM_REQ so one subtract suffices
   function automatic logic [c_ptr_w-1:0] f_wrap_add(input logic [c_ptr_w-1:0] base,
                                                     input logic [c_ptr_w:0]   offs);
      logic [c_ptr_w:0] sum;
      sum = {1'b0, base} + offs;
      if (sum >= c_num) begin
         sum = sum - c_num;
      end
      return sum[c_ptr_w-1:0];
   endfunction

   always_comb begin
      logic [c_ptr_w-1:0] idx;
      w_win_idx   = r_ptr;
      w_win_found = 1'b0;
      idx         = r_ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = f_wrap_add(r_ptr, k[c_ptr_w:0]);
         if (!w_win_found && req[idx]) begin
            w_win_idx   = idx;
            w_win_found = 1'b1;
         end
      end
   end

   assign w_win_byte   = data[{w_win_idx, 3'b000} +: 8];
   assign w_win_onehot = NUM_REQ'(1) << w_win_idx;
   assign w_ptr_next   = f_wrap_add(r_winner, (c_ptr_w + 1)'(1));

`ifdef UART_TX_ARB_WATCHDOG_EN
   logic [7:0] r_wd_cnt;
   logic       r_err;
   logic       w_wd_expire;

   // Abort on the cycle whose increment would bring the count to WD_LIMIT
   assign w_wd_expire = (r_wd_cnt == 8'(WD_LIMIT - 1));
   assign err         = r_err;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ARB_IDLE;
         r_ptr    <= '0;
         r_winner <= '0;
         grant    <= '0;
         ack      <= '0;
         tx_start <= 1'b0;
         tx_data  <= 8'h00;
`ifdef UART_TX_ARB_WATCHDOG_EN
         r_wd_cnt <= 8'h00;
         r_err    <= 1'b0;
`endif
      end else begin
         ack <= '0;
`ifdef UART_TX_ARB_WATCHDOG_EN
         r_err <= 1'b0;
`endif
         if (!en) begin
            // Abandon any frame in flight; the pointer is deliberately kept
            r_state  <= ARB_IDLE;
            tx_start <= 1'b0;
            grant    <= '0;
         end else begin
            case (r_state)
               ARB_IDLE: begin
                  if (w_win_found) begin
                     r_winner <= w_win_idx;
                     tx_data  <= w_win_byte;
                     grant    <= w_win_onehot;
                     tx_start <= 1'b1;
                     r_state  <= LAUNCH;
`ifdef UART_TX_ARB_WATCHDOG_EN
                     r_wd_cnt <= 8'h00;
`endif
                  end
               end
               LAUNCH: begin
                  if (tx_busy) begin
                     tx_start <= 1'b0;
                     r_state  <= SEND;
`ifdef UART_TX_ARB_WATCHDOG_EN
                     r_wd_cnt <= 8'h00;
                  end else if (w_wd_expire) begin
                     tx_start <= 1'b0;
                     r_err    <= 1'b1;
                     r_ptr    <= w_ptr_next;
                     r_state  <= RELEASE;
                  end else begin
                     r_wd_cnt <= r_wd_cnt + 8'h01;
`endif
                  end
               end
               SEND: begin
                  if (tx_done) begin
                     ack     <= grant;
                     r_ptr   <= w_ptr_next;
                     r_state <= RELEASE;
`ifdef UART_TX_ARB_WATCHDOG_EN
                  end else if (w_wd_expire) begin
                     r_err   <= 1'b1;
                     r_ptr   <= w_ptr_next;
                     r_state <= RELEASE;
                  end else begin
                     r_wd_cnt <= r_wd_cnt + 8'h01;
`endif
                  end
               end
               RELEASE: begin
                  if (!tx_busy && !tx_done) begin
                     r_state <= GAP;
                  end
               end
               GAP: begin
                  grant   <= '0;
                  r_state <= ARB_IDLE;
               end
               default: begin
                  r_state <= ARB_IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/uart8_tx_arbiter.md
# uart8_tx_arbiter

Round-robin arbiter that shares one 8-bit UART transmitter among `NUM_REQ` byte producers. It accepts per-requester byte requests and drives the transmitter's `start`/`in` inputs, one frame at a time. It watches the transmitter's `busy`/`done` outputs to sequence each frame, and returns a one-cycle acknowledge to the requester whose byte completed. It runs on the baud-rate clock, alongside the transmitter it controls.

## Interface
- `NUM_REQ`, 4: number of requesters; legal range 2..8.
- `WD_LIMIT`, 15: watchdog limit in clk cycles. Used only when `UART_TX_ARB_WATCHDOG_EN` is defined. Legal range 4..255.

- `clk` input 1: baud-rate clock, shared with the transmitter.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: block enable; wired to the transmitter `en` as well.
- `req` input NUM_REQ: per-requester request level; bit i high means `data[8i+7:8i]` is valid.
- `data` input 8*NUM_REQ: packed request bytes; requester i uses `data[8i+7:8i]`.
- `grant` output NUM_REQ: one-hot; indicates which requester currently owns the transmitter.
- `ack` output NUM_REQ: one-cycle pulse on bit i when requester i's frame has completed.
- `err` output 1: one-cycle pulse when the watchdog aborts a frame.
- `tx_start` output 1: drives transmitter `start`.
- `tx_data` output 8: drives transmitter `in`; registered copy of the winning byte.
- `tx_busy` input 1: transmitter `busy`.
- `tx_done` input 1: transmitter `done`.

## Operation
- **Reset values:** `grant`=0, `ack`=0, `err`=0, `tx_start`=0, `tx_data`=8'h00, state=`ARB_IDLE`, round-robin pointer=0.
- **`ARB_IDLE`**
  - If `en` and `req`≠0: select the winner, latch its byte into `tx_data`, set the one-hot `grant`, set `tx_start`=1, go to `LAUNCH`.
  - Winner selection: search requester indices ascending from the pointer, wrapping modulo `NUM_REQ`; the first set `req` bit wins.
- **`LAUNCH`:** hold `tx_start`=1. When `tx_busy`=1: set `tx_start`=0, go to `SEND`.
  - `tx_start` must be low before the transmitter reaches its stop bit, so no back-to-back frame is triggered.
- **`SEND`:** when `tx_done`=1:
  - pulse `ack[winner]` for one cycle;
  - set pointer = (winner+1) mod `NUM_REQ`;
  - go to `RELEASE`.
- **`RELEASE`:** wait until `tx_busy`=0 and `tx_done`=0, then go to `GAP`.
- **`GAP`:** one cycle; clear `grant`, go to `ARB_IDLE`. This guarantees the transmitter has returned to idle before the next `tx_start`.
- **Requester obligations:**
  - Hold `req` and `data` stable from assertion until its `ack` pulse.
  - `data` is sampled only in `ARB_IDLE`.
  - Dropping `req` after being granted does not cancel the frame; `ack` still pulses.
- **`en`=0 (synchronous):**
  - Next edge: state=`ARB_IDLE`, `tx_start`=0, `grant`=0.
  - No `ack` is issued for an aborted frame.
  - The pointer is retained.
- **`rst_n` low at any point:** all outputs take their reset values immediately, and the pointer is cleared.
- **Simultaneous events:**
  - A `req` arriving in the same cycle as an `ack` is considered only at the next `ARB_IDLE`.
  - `ack` and a new `grant` never occur in the same cycle.

## Timing
- **Grant latency:** `grant`/`tx_start` are asserted on the first edge after `req` is seen in `ARB_IDLE`.
- **Per-frame time, requester to `ack`:** one arbitration cycle, transmitter start latency, start bit, 8 data bits, and the stop bit.
- **Frame spacing:** at least 3 clk cycles of idle line between consecutive frames (`RELEASE` ≥1, `GAP`=1, transmitter reset→idle). This block does not attempt full-bandwidth back-to-back transmission.
- **Fairness:** with all requesters active, each is granted once per `NUM_REQ` frames.

## Configuration
- **`UART_TX_ARB_WATCHDOG_EN` defined:**
  - An 8-bit counter clears on entry to `LAUNCH` and `SEND`, and increments every cycle in those states.
  - If it reaches `WD_LIMIT` in `LAUNCH` (no `tx_busy`) or in `SEND` (no `tx_done`): `tx_start`=0, `err` pulses for 1 cycle, no `ack` is issued, and the pointer advances past the winner.
  - Then go to `RELEASE`.
- **Undefined:**
  - No counter; `err` is tied to 0.
  - `LAUNCH`/`SEND` wait indefinitely.

## Test plan
- **Single request:** `NUM_REQ`=4; `req`=4'b0100 with byte 8'hA5.
  - `grant`=4'b0100 and `tx_start` pulse.
  - Transmitter line shows start bit, 1,0,1,0,0,1,0,1, then the stop bit.
  - `ack`=4'b0100 for exactly 1 cycle; `grant` returns to 0.
- **Fairness:** `req`=4'b1111 held, bytes 8'h00..8'h03.
  - Frames go out in order 0,1,2,3,0.
  - Each `ack` bit pulses once per 4 frames.
- **Wrap-around:** pointer=3 after one grant to requester 2; then `req`=4'b1001.
  - Requester 3 is granted, then requester 0.
- **Mid-frame disable and reset:**
  - `en`=0 in `SEND` → `tx_start`=0, `grant`=0 next edge; no `ack`; the same requester is re-granted after `en`=1.
  - `rst_n` pulsed low mid-frame → all outputs 0 immediately.
- **Watchdog** (macro defined, `WD_LIMIT`=15): `tx_busy` tied 0.
  - `err` pulses on the 15th cycle in `LAUNCH`; no `ack`; the next requester is granted.
  - Macro undefined: `err` stays 0 and `grant` holds.
